// File: rtl/cfg_info_reader.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_info_reader
//  Purpose  : Packs the derived core configuration into a 32-bit word map.
//             Words are served by indexed reads over a valid/ready pair, or
//             streamed in order by a self-driven dump sequence.
//  Options  : CFG_INFO_READER_CRC_EN adds word 11, the XOR of words 0..10.
//  Revision : 1.0  initial release
// ============================================================================

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
        int unsigned VLEN;
        int unsigned GPLEN;
        bit RVA;      bit RVB;      bit RVC;       bit RVD;
        bit RVF;      bit RVH;      bit RVS;       bit RVU;
        bit RVV;      bit ZKN;      bit RVZCB;     bit RVZCMP;
        bit RVZCMT;   bit RVZiCond; bit RVZicntr;  bit RVZihpm;
        bit XF16;     bit XF16ALT;  bit XF8;       bit XFVec;
        bit CvxifEn;  bit SuperscalarEn; bit FusionEn; bit DebugEn;
        bit MmuPresent; bit PerfCounterEn;
        int unsigned NrIssuePorts;
        int unsigned NrCommitPorts;
        int unsigned NrWbPorts;
        int unsigned NrRgprPorts;
        int unsigned NR_SB_ENTRIES;
        int unsigned TRANS_ID_BITS;
        int unsigned FLen;
        int unsigned NrLoadBufEntries;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned InstrTlbEntries;
        int unsigned DataTlbEntries;
        int unsigned SharedTlbDepth;
        int unsigned PtLevels;
        int unsigned AxiAddrWidth;
        int unsigned AxiDataWidth;
        int unsigned AxiIdWidth;
        int unsigned AxiUserWidth;
        int unsigned FETCH_WIDTH;
        int unsigned INSTR_PER_FETCH;
        int unsigned RASDepth;
        int unsigned BTBEntries;
        int unsigned BHTEntries;
        int unsigned NrPMPEntries;
        int unsigned MaxOutstandingStores;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module cfg_info_reader #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NrWords      = 16,
    parameter int unsigned           OutFifoDepth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [$clog2(NrWords)-1:0] req_addr_i,
    input  logic                       dump_start_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [31:0]                rsp_data_o,
    output logic [$clog2(NrWords)-1:0] rsp_addr_o,
    output logic                       rsp_err_o,
    output logic                       busy_o
);

    localparam int unsigned c_AW = $clog2(NrWords);
`ifdef CFG_INFO_READER_CRC_EN
    localparam int unsigned c_LAST_DEF = 11;
`else
    localparam int unsigned c_LAST_DEF = 10;
`endif
    localparam int unsigned c_PW = (OutFifoDepth > 1) ? $clog2(OutFifoDepth) : 1;
    localparam int unsigned c_CW = $clog2(OutFifoDepth + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DUMP = 2'd1, S_DRAIN = 2'd2} state_t;

    // Oversized values clamp to all-ones so a reader never sees a wrapped value
    function automatic logic [7:0] f_sat8(input int unsigned v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [15:0] f_sat16(input int unsigned v);
        return (v > 32'd65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [31:0] f_word(input int unsigned idx);
        logic [31:0] w;
        w = '0;
        case (idx)
            0: w = 32'h43564136;
            1: w = {f_sat8(CVA6Cfg.XLEN), f_sat8(CVA6Cfg.PLEN),
                    f_sat8(CVA6Cfg.VLEN), f_sat8(CVA6Cfg.GPLEN)};
            2: w = {6'd0, CVA6Cfg.PerfCounterEn, CVA6Cfg.MmuPresent,
                    CVA6Cfg.DebugEn, CVA6Cfg.FusionEn, CVA6Cfg.SuperscalarEn, CVA6Cfg.CvxifEn,
                    CVA6Cfg.XFVec, CVA6Cfg.XF8, CVA6Cfg.XF16ALT, CVA6Cfg.XF16,
                    CVA6Cfg.RVZihpm, CVA6Cfg.RVZicntr, CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMT,
                    CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB, CVA6Cfg.ZKN, CVA6Cfg.RVV,
                    CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.RVH, CVA6Cfg.RVF,
                    CVA6Cfg.RVD, CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
            3: w = {f_sat8(CVA6Cfg.NrIssuePorts), f_sat8(CVA6Cfg.NrCommitPorts),
                    f_sat8(CVA6Cfg.NrWbPorts), f_sat8(CVA6Cfg.NrRgprPorts)};
            4: w = {f_sat8(CVA6Cfg.NR_SB_ENTRIES), f_sat8(CVA6Cfg.TRANS_ID_BITS),
                    f_sat8(CVA6Cfg.FLen), f_sat8(CVA6Cfg.NrLoadBufEntries)};
            5: w = {f_sat8(CVA6Cfg.ICACHE_SET_ASSOC), f_sat8(CVA6Cfg.ICACHE_INDEX_WIDTH),
                    f_sat16(CVA6Cfg.ICACHE_LINE_WIDTH)};
            6: w = {f_sat8(CVA6Cfg.DCACHE_SET_ASSOC), f_sat8(CVA6Cfg.DCACHE_INDEX_WIDTH),
                    f_sat16(CVA6Cfg.DCACHE_LINE_WIDTH)};
            7: w = {f_sat8(CVA6Cfg.InstrTlbEntries), f_sat8(CVA6Cfg.DataTlbEntries),
                    f_sat8(CVA6Cfg.SharedTlbDepth), f_sat8(CVA6Cfg.PtLevels)};
            8: w = {f_sat8(CVA6Cfg.AxiAddrWidth), f_sat8(CVA6Cfg.AxiDataWidth),
                    f_sat8(CVA6Cfg.AxiIdWidth), f_sat8(CVA6Cfg.AxiUserWidth)};
            9: w = {f_sat8(CVA6Cfg.FETCH_WIDTH), f_sat8(CVA6Cfg.INSTR_PER_FETCH),
                    f_sat8(CVA6Cfg.RASDepth), f_sat8(CVA6Cfg.BTBEntries)};
            10: w = {f_sat16(CVA6Cfg.BHTEntries), f_sat8(CVA6Cfg.NrPMPEntries),
                     f_sat8(CVA6Cfg.MaxOutstandingStores)};
            default: w = '0;
        endcase
        return w;
    endfunction

`ifdef CFG_INFO_READER_CRC_EN
    function automatic logic [31:0] f_crc();
        logic [31:0] c;
        c = '0;
        for (int i = 0; i <= 10; i++) c = c ^ f_word(i);
        return c;
    endfunction
    localparam logic [31:0] c_CRC = f_crc();
`endif

    state_t               r_state, w_state_nxt;
    logic [c_AW-1:0]      r_cnt, w_cnt_nxt;
    logic [c_PW-1:0]      r_wptr, r_rptr;
    logic [c_CW-1:0]      r_count;
    logic [31:0]          r_mem_data [OutFifoDepth];
    logic [c_AW-1:0]      r_mem_addr [OutFifoDepth];
    logic                 r_mem_err  [OutFifoDepth];

    logic [c_AW-1:0]      w_lk_addr;
    logic [31:0]          w_lk_data;
    logic                 w_lk_err;
    logic                 w_rsp_valid, w_pop, w_room, w_push, w_req_ready;

    assign w_rsp_valid = rst_ni && (r_count != '0);
    assign w_pop       = w_rsp_valid && rsp_ready_i;
    assign w_room      = (r_count != c_CW'(OutFifoDepth)) || w_pop;

    // Word lookup: external index while idle, dump counter otherwise
    always_comb begin
        w_lk_addr = (r_state == S_IDLE) ? req_addr_i : r_cnt;
        w_lk_data = '0;
        w_lk_err  = 1'b1;
        if (32'(w_lk_addr) <= c_LAST_DEF) begin
            w_lk_err  = 1'b0;
            w_lk_data = f_word(32'(w_lk_addr));
`ifdef CFG_INFO_READER_CRC_EN
            if (32'(w_lk_addr) == c_LAST_DEF) w_lk_data = c_CRC;
`endif
        end
    end

    // State and dump counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, request acceptance and FIFO push decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_req_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = !dump_start_i && w_room;
                w_push      = req_valid_i && w_req_ready;
                if (dump_start_i) w_state_nxt = S_DUMP;
            end
            S_DUMP: begin
                if (w_room) begin
                    w_push    = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_AW'(c_LAST_DEF)) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep occupancy
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == c_PW'(OutFifoDepth - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == c_PW'(OutFifoDepth - 1)) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_lk_data;
            r_mem_addr[r_wptr] <= w_lk_addr;
            r_mem_err[r_wptr]  <= w_lk_err;
        end
    end

    // All outputs are forced low while reset is held
    assign req_ready_o = rst_ni && w_req_ready;
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_data_o  = rst_ni ? r_mem_data[r_rptr] : '0;
    assign rsp_addr_o  = rst_ni ? r_mem_addr[r_rptr] : '0;
    assign rsp_err_o   = rst_ni && r_mem_err[r_rptr];
    assign busy_o      = rst_ni && (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cfg_info_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_info_reader
//  Purpose  : Directed self-checking bench for cfg_info_reader using a
//             cv64a6-style configuration plus a clamped-field instance.
//  Options  : CFG_INFO_READER_CRC_EN selects the 12-word map expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cfg_info_reader;

    function automatic config_pkg::cva6_cfg_t f_cfg(input int unsigned bht);
        config_pkg::cva6_cfg_t c;
        c = '0;
        c.XLEN = 64; c.PLEN = 56; c.VLEN = 64; c.GPLEN = 41;
        c.RVA = 1; c.RVB = 1; c.RVC = 1; c.RVD = 1; c.RVF = 1; c.RVS = 1; c.RVU = 1;
        c.ZKN = 1; c.RVZCB = 1; c.RVZiCond = 1; c.RVZicntr = 1; c.RVZihpm = 1;
        c.CvxifEn = 1; c.DebugEn = 1; c.MmuPresent = 1; c.PerfCounterEn = 1;
        c.NrIssuePorts = 1; c.NrCommitPorts = 2; c.NrWbPorts = 4; c.NrRgprPorts = 2;
        c.NR_SB_ENTRIES = 8; c.TRANS_ID_BITS = 3; c.FLen = 64; c.NrLoadBufEntries = 2;
        c.ICACHE_SET_ASSOC = 4; c.ICACHE_INDEX_WIDTH = 12; c.ICACHE_LINE_WIDTH = 128;
        c.DCACHE_SET_ASSOC = 8; c.DCACHE_INDEX_WIDTH = 12; c.DCACHE_LINE_WIDTH = 128;
        c.InstrTlbEntries = 16; c.DataTlbEntries = 16; c.SharedTlbDepth = 64; c.PtLevels = 3;
        c.AxiAddrWidth = 64; c.AxiDataWidth = 64; c.AxiIdWidth = 4; c.AxiUserWidth = 32;
        c.FETCH_WIDTH = 32; c.INSTR_PER_FETCH = 2; c.RASDepth = 2; c.BTBEntries = 32;
        c.BHTEntries = bht; c.NrPMPEntries = 8; c.MaxOutstandingStores = 7;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t C_CFG       = f_cfg(128);
    localparam config_pkg::cva6_cfg_t C_CFG_CLAMP = f_cfg(70000);
`ifdef CFG_INFO_READER_CRC_EN
    localparam int N_DUMP = 12;
`else
    localparam int N_DUMP = 11;
`endif

    logic        clk_i, rst_ni;
    logic        req_valid_i, req_ready_o, dump_start_i;
    logic [3:0]  req_addr_i, rsp_addr_o;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
    logic [31:0] rsp_data_o;

    logic        b_req_valid, b_req_ready, b_dump_start, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [3:0]  b_req_addr, b_rsp_addr;
    logic [31:0] b_rsp_data;

    int          n_vec, n_err, k, cyc;
    logic [31:0] exp_w [0:11];

    cfg_info_reader #(.CVA6Cfg(C_CFG), .NrWords(16), .OutFifoDepth(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .dump_start_i(dump_start_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_addr_o(rsp_addr_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    cfg_info_reader #(.CVA6Cfg(C_CFG_CLAMP), .NrWords(16), .OutFifoDepth(2)) dut_clamp (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
        .dump_start_i(b_dump_start),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
        .rsp_addr_o(b_rsp_addr), .rsp_err_o(b_rsp_err), .busy_o(b_busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Single read with the consumer ready: accept, then response one cycle later
    task automatic read1(input logic [3:0] idx, input logic [31:0] ed, input logic ee, input string tag);
        req_valid_i = 1'b1; req_addr_i = idx; rsp_ready_i = 1'b1;
        #2;
        chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        #2;
        chk({tag, ".valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, ".data"},  rsp_data_o, ed);
        chk({tag, ".addr"},  32'(rsp_addr_o), 32'(idx));
        chk({tag, ".err"},   32'(rsp_err_o), 32'(ee));
        step();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_w[0]  = 32'h43564136; exp_w[1]  = 32'h40384029; exp_w[2]  = 32'h0390E6DF;
        exp_w[3]  = 32'h01020402; exp_w[4]  = 32'h08034002; exp_w[5]  = 32'h040C0080;
        exp_w[6]  = 32'h080C0080; exp_w[7]  = 32'h10104003; exp_w[8]  = 32'h40400420;
        exp_w[9]  = 32'h20020220; exp_w[10] = 32'h00800807; exp_w[11] = 32'h0;
        for (int i = 0; i <= 10; i++) exp_w[11] = exp_w[11] ^ exp_w[i];

        rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; dump_start_i = 1'b0; rsp_ready_i = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_dump_start = 1'b0; b_rsp_ready = 1'b0;

        // Reset state
        #2;
        chk("rst.ready0", 32'(req_ready_o), 32'd0);
        repeat (3) step();
        chk("rst.ready", 32'(req_ready_o), 32'd0);
        chk("rst.valid", 32'(rsp_valid_o), 32'd0);
        chk("rst.busy",  32'(busy_o), 32'd0);
        chk("rst.data",  rsp_data_o, 32'd0);
        rst_ni = 1'b1;
        #2;
        chk("idle.ready", 32'(req_ready_o), 32'd1);
        chk("idle.valid", 32'(rsp_valid_o), 32'd0);
        step();

        // Basic reads, reserved indices, and the whole map
        read1(4'd0, 32'h43564136, 1'b0, "rd0");
        read1(4'd1, 32'h40384029, 1'b0, "rd1");
        read1(4'd15, 32'h0, 1'b1, "rd15");
`ifdef CFG_INFO_READER_CRC_EN
        read1(4'd11, exp_w[11], 1'b0, "rd11");
`else
        read1(4'd11, 32'h0, 1'b1, "rd11");
`endif
        for (int i = 2; i <= 10; i++) read1(4'(i), exp_w[i], 1'b0, "rdmap");

        // Back-pressure: two accepted, third refused until the first pop
        rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 4'd2;
        #2; chk("bp.rdy2", 32'(req_ready_o), 32'd1);
        step();
        req_addr_i = 4'd3;
        #2; chk("bp.rdy3", 32'(req_ready_o), 32'd1);
        chk("bp.head2a", rsp_data_o, exp_w[2]);
        step();
        req_addr_i = 4'd4;
        #2; chk("bp.rdy4_full", 32'(req_ready_o), 32'd0);
        chk("bp.head2b", 32'(rsp_addr_o), 32'd2);
        step();
        #2; chk("bp.rdy4_still", 32'(req_ready_o), 32'd0);
        chk("bp.head2c", rsp_data_o, exp_w[2]);
        rsp_ready_i = 1'b1;
        #1; chk("bp.rdy4_pop", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        #2; chk("bp.head3", 32'(rsp_addr_o), 32'd3);
        chk("bp.data3", rsp_data_o, exp_w[3]);
        step();
        #2; chk("bp.head4", 32'(rsp_addr_o), 32'd4);
        chk("bp.data4", rsp_data_o, exp_w[4]);
        step();
        #2; chk("bp.empty", 32'(rsp_valid_o), 32'd0);
        step();

        // Dump with a colliding request, which must be refused
        dump_start_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 4'd5; rsp_ready_i = 1'b1;
        #2; chk("dump.refuse", 32'(req_ready_o), 32'd0);
        step();
        dump_start_i = 1'b0; req_valid_i = 1'b0;
        #2; chk("dump.busy", 32'(busy_o), 32'd1);
        k = 0; cyc = 0;
        while (k < N_DUMP && cyc < 60) begin
            if (rsp_valid_o) begin
                chk("dump.addr", 32'(rsp_addr_o), 32'(k));
                chk("dump.data", rsp_data_o, exp_w[k]);
                chk("dump.err",  32'(rsp_err_o), 32'd0);
                k++;
            end
            step(); #2; cyc++;
        end
        chk("dump.count", 32'(k), 32'(N_DUMP));
        chk("dump.empty", 32'(rsp_valid_o), 32'd0);
        step(); #2;
        chk("dump.idle", 32'(busy_o), 32'd0);
        chk("dump.ready", 32'(req_ready_o), 32'd1);
        step();

        // Reset in the middle of a dump
        dump_start_i = 1'b1;
        step();
        dump_start_i = 1'b0;
        #2;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 40) begin
            if (rsp_valid_o) k++;
            step(); #2; cyc++;
        end
        chk("abort.count", 32'(k), 32'd4);
        rst_ni = 1'b0;
        #1;
        chk("abort.ready", 32'(req_ready_o), 32'd0);
        chk("abort.valid", 32'(rsp_valid_o), 32'd0);
        chk("abort.busy",  32'(busy_o), 32'd0);
        chk("abort.data",  rsp_data_o, 32'd0);
        chk("abort.addr",  32'(rsp_addr_o), 32'd0);
        chk("abort.err",   32'(rsp_err_o), 32'd0);
        step();
        rst_ni = 1'b1;
        #2;
        chk("post.busy",  32'(busy_o), 32'd0);
        chk("post.valid", 32'(rsp_valid_o), 32'd0);
        chk("post.ready", 32'(req_ready_o), 32'd1);
        step();
        read1(4'd0, 32'h43564136, 1'b0, "post.rd0");

        // Clamped 16-bit field
        b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_req_addr = 4'd10;
        #2; chk("clamp.ready", 32'(b_req_ready), 32'd1);
        step();
        b_req_valid = 1'b0;
        #2;
        chk("clamp.valid", 32'(b_rsp_valid), 32'd1);
        chk("clamp.word10", b_rsp_data, 32'hFFFF0807);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
